// File: rtl/memory_arbiter_pkg.sv
// Shared constants and types for the three-requester RAM arbiter.
// Covers the FSM state encoding, the grant_id codes and the 512x8 RAM geometry.
package memory_arbiter_pkg;

  localparam int unsigned RAM_DEPTH  = 512;
  localparam int unsigned RAM_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    ERR    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_IF   = 2'b01,
    GRANT_DM   = 2'b10,
    GRANT_LD   = 2'b11
  } grant_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RAM_WIDTH-1:0]  wdata;
  } cmd_t;

endpackage

// File: rtl/memory_arbiter_arb_priority.sv
// Fixed-priority requester selection (loader > data > fetch).
// Fetch overtakes data, but never the loader, once it has starved long enough.
module arb_priority
  import memory_arbiter_pkg::*;
(
  input  logic   ld_req,
  input  logic   dm_req,
  input  logic   if_req,
  input  logic   starve_hit,
  output grant_t grant
);

  always_comb begin
    grant = GRANT_NONE;
    if (ld_req) begin
      grant = GRANT_LD;
    end else if (if_req && starve_hit) begin
      grant = GRANT_IF;
    end else if (dm_req) begin
      grant = GRANT_DM;
    end else if (if_req) begin
      grant = GRANT_IF;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates loader, data-unit and fetch requests onto a single 512x8 RAM port.
// Adds a starvation guard for fetch and a timeout when ram_mfc never arrives.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  ld_req,
  input  logic                  dm_req,
  input  logic                  if_req,
  input  logic                  ld_rw,
  input  logic                  dm_rw,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [RAM_WIDTH-1:0]  ld_wdata,
  input  logic [RAM_WIDTH-1:0]  dm_wdata,
  output logic                  ld_ack,
  output logic                  dm_ack,
  output logic                  if_ack,
  output logic                  err,
  output logic [RAM_WIDTH-1:0]  rdata,
  output logic                  ram_enable,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_wdata,
  input  logic [RAM_WIDTH-1:0]  ram_rdata,
  input  logic                  ram_mfc,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t          state;
  grant_t          grant;
  cmd_t            sel_cmd;
  logic [TW-1:0]   tmo_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            starve_hit;

  assign starve_hit = (starve_cnt == STARVE_MAX);

  arb_priority u_arb_priority (
    .ld_req     (ld_req),
    .dm_req     (dm_req),
    .if_req     (if_req),
    .starve_hit (starve_hit),
    .grant      (grant)
  );

  always_comb begin
    sel_cmd = '{rw: 1'b0, addr: if_addr, wdata: '0};
    case (grant)
      GRANT_LD: sel_cmd = '{rw: ld_rw, addr: ld_addr, wdata: ld_wdata};
      GRANT_DM: sel_cmd = '{rw: dm_rw, addr: dm_addr, wdata: dm_wdata};
      default:  ;
    endcase
  end

  // Acks/err are one-cycle pulses: cleared by default every edge and set only on
  // entry to DONE/ERR, so they are high exactly while the FSM sits in those states.
  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      ld_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_ack     <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      ram_enable <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= GRANT_NONE;
    end else begin
      ld_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          rdata <= '0;
          if (grant != GRANT_NONE) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            grant_id   <= grant;
            ram_enable <= 1'b1;
            ram_rw     <= sel_cmd.rw;
            ram_addr   <= sel_cmd.addr;
            ram_wdata  <= sel_cmd.wdata;
            tmo_cnt    <= '0;
            if (grant == GRANT_IF || !if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else if (!if_req) begin
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          if (ram_mfc || tmo_cnt == TMO_LAST) begin
            state      <= ram_mfc ? DONE : ERR;
            err        <= !ram_mfc;
            rdata      <= (ram_mfc && !ram_rw) ? ram_rdata : '0;
            ld_ack     <= (grant_id == GRANT_LD);
            dm_ack     <= (grant_id == GRANT_DM);
            if_ack     <= (grant_id == GRANT_IF);
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant_id <= GRANT_NONE;
          rdata    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of ACCESS cycles to wait for ram_mfc.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive non-fetch grants allowed while fetch is pending.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: main_clk input 1, clock; reset input 1, asynchronous active-low reset.
REQ-004 SHALL have ports ld_req, dm_req, if_req input 1 each, requests from the loader, the data (load/store) unit and instruction fetch.
REQ-005 SHALL have ports ld_rw, dm_rw input 1 each (1=write), write-enable per requester; fetch is read-only.
REQ-006 SHALL have ports ld_addr, dm_addr, if_addr input 9 each, byte address into the 512x8 RAM.
REQ-007 SHALL have ports ld_wdata, dm_wdata input 8 each, write data.
REQ-008 SHALL have ports ld_ack, dm_ack, if_ack output 1 each, one-cycle completion pulse per requester.
REQ-009 SHALL have port err output 1, a one-cycle pulse together with ack on timeout.
REQ-010 SHALL have port rdata output 8, read data, valid while any ack is high.
REQ-011 SHALL have ports ram_enable output 1, ram_rw output 1, ram_addr output 9 and ram_wdata output 8, the RAM command.
REQ-012 SHALL have ports ram_rdata input 8 and ram_mfc input 1 (memory function complete).
REQ-013 SHALL have ports busy output 1 and grant_id output 2 (00 none, 01 fetch, 10 data, 11 loader).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-015 IDLE: sample requests at each edge; if any are high, latch the winner's rw/addr/wdata and go to ACCESS.
REQ-016 Priority SHALL be loader > data > fetch, except when the starve counter is at STARVE_LIMIT with if_req high, in which case fetch wins over data (not over loader).
REQ-017 Starve counter: increment on each loader/data grant while if_req is high, clear on a fetch grant or when if_req is low; saturate at STARVE_LIMIT.
REQ-018 ACCESS: ram_enable=1 and ram_rw/ram_addr/ram_wdata driven from latched values; requester inputs SHALL be ignored.
REQ-019 ACCESS: on ram_mfc=1, latch ram_rdata (reads) and go to DONE; writes drive rdata 0x00.
REQ-020 ACCESS: a cycle counter counts ACCESS cycles; when it reaches TIMEOUT with ram_mfc low, go to ERR.
REQ-021 DONE: pulse the granted requester's ack for exactly one cycle, then go to IDLE.
REQ-022 ERR: pulse the granted ack and err for one cycle with rdata=0x00, then go to IDLE.
REQ-023 Minimum latency: req sampled at edge k with mfc high in the first ACCESS cycle -> ack high in cycle k+2; a back-to-back request can be sampled at edge k+3.
REQ-024 A requester SHALL drop req at the edge where its ack is sampled; req still high in IDLE starts a new transaction.
REQ-025 Dropping req during ACCESS SHALL NOT abort the transaction; ack is still issued.
REQ-026 busy=1 in ACCESS/DONE/ERR; grant_id holds the winner from ACCESS through DONE/ERR and is 00 in IDLE.
REQ-027 ram_mfc outside ACCESS SHALL be ignored.

Reset
REQ-028 Reset low SHALL force IDLE immediately, including mid-ACCESS (the transaction is dropped with no ack).
REQ-029 During reset all outputs SHALL be 0 and the starve counter and timeout counter SHALL be cleared.

Structure
REQ-030 The state encoding, grant_id codes, RAM depth (512) and width (8) constants SHALL live in a shared memory package.
REQ-031 No sub-module is required; the priority/starve selection MAY be a sub-module named arb_priority.

Verification
REQ-032 if_req, if_addr=0x005, mfc in the first ACCESS cycle, ram_rdata=0xA5 -> if_ack in cycle k+2, rdata=0xA5, grant_id=01.
REQ-033 ld_req and dm_req and if_req all high in the same cycle -> loader served first, then data, then fetch.
REQ-034 dm_req held continuously with if_req high -> fetch granted after 4 data grants.
REQ-035 dm write addr=0x1FF data=0x3C with mfc never asserted -> dm_ack and err after 15 ACCESS cycles, rdata=0x00.
REQ-036 Reset asserted during ACCESS -> all outputs 0 asynchronously, no ack; after release, IDLE accepts a new request.
REQ-037 A stray ram_mfc pulse in IDLE -> no state change and no ack.
